// File: rtl/riscv_config_pkg.sv
// Core-wide build configuration shared by the execute-stage units.
package riscv_config_pkg;

    localparam int DEFAULT_MULT_LATENCY = 2;

endpackage

// File: rtl/riscv_core_pkg.sv
// Core types and encodings shared between the issue sequencer and the multiplier.
package riscv_core_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } mdu_cause_e;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;

    // Only funct3 values 0xx are multiplies; 1xx are divide/remainder.
    function automatic logic mul_op_legal(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mult_unit.sv
// Pipelined RV32M multiplier: result and done emerge LATENCY cycles after start.
// A new start discards any op still in the pipeline.
module mult_unit
    import riscv_core_pkg::*;
    import riscv_config_pkg::*;
#(
    parameter int LATENCY = DEFAULT_MULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  op_type_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        done_o
);

    logic               a_signed;
    logic               b_signed;
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    word_t              prod_sel;

    word_t              res_q [LATENCY];
    logic [LATENCY-1:0] vld_q;

    always_comb begin
        a_signed = (op_type_i == MUL_OP_MULH) || (op_type_i == MUL_OP_MULHSU);
        b_signed = (op_type_i == MUL_OP_MULH);
        a_ext    = {{32{a_signed & a_i[31]}}, a_i};
        b_ext    = {{32{b_signed & b_i[31]}}, b_i};
        prod     = a_ext * b_ext;
        prod_sel = (op_type_i == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) res_q[i] <= '0;
        end else begin
            vld_q    <= start_i ? LATENCY'(1) : (vld_q << 1);
            res_q[0] <= prod_sel;
            for (int i = 1; i < LATENCY; i++) res_q[i] <= res_q[i-1];
        end
    end

    assign result_o = res_q[LATENCY-1];
    assign done_o   = vld_q[LATENCY-1];

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/response sequencer between execute and mult_unit, with watchdog and flush.
//   state  | meaning
//   S_IDLE | no op outstanding, ready for a request
//   S_WAIT | start issued, waiting for mul_done_i or watchdog expiry
//   S_RESP | response registered, held until writeback handshakes
module mult_issue_ctrl
    import riscv_core_pkg::*;
    import riscv_config_pkg::*;
#(
    parameter int LATENCY        = DEFAULT_MULT_LATENCY,
    parameter int TIMEOUT_CYCLES = LATENCY + 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [4:0]  req_rd_i,
    output logic        mul_start_o,
    output logic [2:0]  mul_op_type_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_done_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_exc_o,
    output logic [1:0]  rsp_cause_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    state_e     state;
    logic [CW-1:0] wd_cnt;
    logic [CW-1:0] wd_next;
    logic       timeout;
    logic       accept;
    logic       op_legal;
    logic       rsp_valid_q;
    word_t      rsp_result_q;
    logic [4:0] rsp_rd_q;
    logic       rsp_exc_q;
    mdu_cause_e rsp_cause_q;

    always_comb begin
        req_ready_o = ((state == S_IDLE) || ((state == S_RESP) && rsp_ready_i)) && !flush_i;
        accept      = req_valid_i && req_ready_o;
        op_legal    = mul_op_legal(req_op_i);
        mul_start_o = accept && op_legal;
        // The watchdog saturates so a stuck multiplier can never wrap it back to quiet.
        wd_next     = (wd_cnt == TO_VAL) ? wd_cnt : wd_cnt + CW'(1);
        timeout     = (wd_next == TO_VAL);
    end

    assign mul_op_type_o = req_op_i;
    assign mul_a_o       = req_a_i;
    assign mul_b_o       = req_b_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            wd_cnt       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_rd_q     <= '0;
            rsp_exc_q    <= 1'b0;
            rsp_cause_q  <= CAUSE_NONE;
        end else if (flush_i) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
        end else if (accept) begin
            rsp_rd_q <= req_rd_i;
            wd_cnt   <= '0;
            if (op_legal) begin
                state       <= S_WAIT;
                rsp_valid_q <= 1'b0;
            end else begin
                state        <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= '0;
                rsp_exc_q    <= 1'b1;
                rsp_cause_q  <= CAUSE_ILLEGAL;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (mul_done_i) begin
                        state        <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= mul_result_i;
                        rsp_exc_q    <= 1'b0;
                        rsp_cause_q  <= CAUSE_NONE;
                    end else if (timeout) begin
                        state        <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_exc_q    <= 1'b1;
                        rsp_cause_q  <= CAUSE_TIMEOUT;
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_rd_o     = rsp_rd_q;
    assign rsp_exc_o    = rsp_exc_q;
    assign rsp_cause_o  = rsp_cause_q;
    assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl driving a real mult_unit; expectations come from
// transaction-level arithmetic and the documented latencies.
module tb_mult_issue_ctrl;
    import riscv_core_pkg::*;
    import riscv_config_pkg::*;

    localparam int LAT = DEFAULT_MULT_LATENCY;
    localparam int TO  = LAT + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        mul_start;
    logic [2:0]  mul_op_type;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_result;
    logic        mul_done_raw;
    logic        mul_done;
    logic        kill_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        rsp_exc;
    logic [1:0]  rsp_cause;
    logic        busy;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign mul_done = mul_done_raw & ~kill_done;

    mult_unit #(.LATENCY(LAT)) u_mul (
        .clk_i    (clk),
        .rst_ni   (~rst),
        .start_i  (mul_start),
        .op_type_i(mul_op_type),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .result_o (mul_result),
        .done_o   (mul_done_raw)
    );

    mult_issue_ctrl #(.LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_rd_i     (req_rd),
        .mul_start_o  (mul_start),
        .mul_op_type_o(mul_op_type),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_result_i (mul_result),
        .mul_done_i   (mul_done),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_rd_o     (rsp_rd),
        .rsp_exc_o    (rsp_exc),
        .rsp_cause_o  (rsp_cause),
        .busy_o       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'b0, b});
        longint unsigned ua_u = {32'b0, a};
        longint unsigned ub_u = {32'b0, b};
        longint          p;
        longint unsigned up;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = ua_u * ub_u; return up[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int t0, input int exp_lat);
        bit seen = 0;
        for (int i = 0; i < 64; i++) begin
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            step();
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) check_eq({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int hold, input string tag);
        bit          legal = (op[2] == 1'b0);
        int          exp_lat;
        int          t0;
        logic [31:0] er;
        logic        eexc;
        logic [1:0]  ecause;
        if (!legal) begin
            exp_lat = 1; er = 0; eexc = 1; ecause = 2'b01;
        end else if (kill_done) begin
            exp_lat = TO + 1; er = 0; eexc = 1; ecause = 2'b10;
        end else begin
            exp_lat = LAT + 1; er = ref_result(op, a, b); eexc = 0; ecause = 2'b00;
        end
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        #1;
        check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_start"}, 64'(mul_start), 64'(legal));
        t0 = cyc;
        step();
        req_valid = 0;
        wait_rsp(tag, t0, exp_lat);
        check_eq({tag, "_result"}, 64'(rsp_result), 64'(er));
        check_eq({tag, "_rd"}, 64'(rsp_rd), 64'(rd));
        check_eq({tag, "_exc"}, 64'(rsp_exc), 64'(eexc));
        check_eq({tag, "_cause"}, 64'(rsp_cause), 64'(ecause));
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
            step();
            check_eq({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check_eq({tag, "_hold_result"}, 64'(rsp_result), 64'(er));
        end
        rsp_ready = 1;
        #1;
        check_eq({tag, "_hs_ready"}, 64'(req_ready), 64'd1);
        step();
        rsp_ready = 0;
        check_eq({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_post_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          t0;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] corner [5];
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;

        rst = 1; flush = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_rd = 0;
        rsp_ready = 0; kill_done = 0;
        step(); step();
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_result", 64'(rsp_result), 64'd0);
        check_eq("rst_cause", 64'(rsp_cause), 64'd0);
        rst = 0;
        step();

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 0, "mul");
        check_eq("mul_value", 64'(ref_result(3'd0, 32'd7, 32'hFFFFFFFD)), 64'hFFFFFFEB);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 4, "mulhu");
        run_op(3'b101, 32'd9, 32'd9, 5'd8, 1, "illegal");

        // Back-to-back: MULHSU accepted in the same cycle MULH's response handshakes.
        req_valid = 1; req_op = 3'd1; req_a = 32'h80000000; req_b = 32'h80000000; req_rd = 5'd7;
        #1;
        check_eq("b2b_start1", 64'(mul_start), 64'd1);
        t0 = cyc;
        step();
        req_valid = 0;
        wait_rsp("b2b_first", t0, LAT + 1);
        check_eq("b2b_first_result", 64'(rsp_result), 64'h40000000);
        rsp_ready = 1;
        req_valid = 1; req_op = 3'd2; req_a = 32'hFFFFFFFF; req_b = 32'd2; req_rd = 5'd9;
        #1;
        check_eq("b2b_ready2", 64'(req_ready), 64'd1);
        check_eq("b2b_start2", 64'(mul_start), 64'd1);
        check_eq("b2b_first_rd", 64'(rsp_rd), 64'd7);
        t0 = cyc;
        step();
        req_valid = 0; rsp_ready = 0;
        check_eq("b2b_gap_valid", 64'(rsp_valid), 64'd0);
        check_eq("b2b_gap_busy", 64'(busy), 64'd1);
        wait_rsp("b2b_second", t0, LAT + 1);
        check_eq("b2b_second_result", 64'(rsp_result), 64'hFFFFFFFF);
        check_eq("b2b_second_rd", 64'(rsp_rd), 64'd9);
        rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Flush one cycle after start; the stale done must not produce a response.
        req_valid = 1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6; req_rd = 5'd3;
        #1;
        step();
        flush = 1; req_a = 32'd3; req_b = 32'd4; req_rd = 5'd4;
        #1;
        check_eq("flush_ready", 64'(req_ready), 64'd0);
        check_eq("flush_start", 64'(mul_start), 64'd0);
        step();
        flush = 0; req_valid = 0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        check_eq("flush_valid", 64'(rsp_valid), 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd4, 0, "flush_new");

        // Flush while a response is pending drops it.
        req_valid = 1; req_op = 3'b110; req_rd = 5'd2;
        #1;
        step();
        req_valid = 0;
        check_eq("flush_resp_pre", 64'(rsp_valid), 64'd1);
        flush = 1;
        step();
        flush = 0;
        check_eq("flush_resp_valid", 64'(rsp_valid), 64'd0);

        kill_done = 1;
        run_op(3'd0, 32'd11, 32'd13, 5'd11, 1, "timeout");
        kill_done = 0;

        // Reset asserted while waiting on the multiplier.
        req_valid = 1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd200; req_rd = 5'd17;
        #1;
        step();
        req_valid = 0;
        step();
        check_eq("rstw_busy_pre", 64'(busy), 64'd1);
        rst = 1;
        step();
        check_eq("rstw_valid", 64'(rsp_valid), 64'd0);
        check_eq("rstw_busy", 64'(busy), 64'd0);
        check_eq("rstw_rd", 64'(rsp_rd), 64'd0);
        check_eq("rstw_exc", 64'(rsp_exc), 64'd0);
        check_eq("rstw_cause", 64'(rsp_cause), 64'd0);
        check_eq("rstw_result", 64'(rsp_result), 64'd0);
        rst = 0;
        step();

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 8) op = 3'($urandom_range(0, 3));
            else                          op = 3'($urandom_range(4, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            run_op(op, a, b, 5'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Issue/response sequencer sitting between the execute stage and the pipelined multiplier unit (`mult_unit`). Accepts RV32M multiply requests over a valid/ready handshake and pulses the multiplier's start with latched destination tag. It then waits for the multiplier's done, captures the 32-bit result into a response register, and holds it until writeback accepts. It also rejects illegal op codes, runs a watchdog on the multiplier, and handles pipeline flush.

## Interface
- `LATENCY`, `DEFAULT_MULT_LATENCY`: multiplier pipeline depth; must match the `mult_unit` instance.
- `TIMEOUT_CYCLES`, `LATENCY+4`: watchdog limit in cycles, counted from start.
- One clock; reset is synchronous and active-high.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset. The parent drives `mult_unit.rst_ni` with `~rst_i`.
- `flush_i` in 1: kill any in-flight or pending operation.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both valid and ready are high.
- `req_op_i` in 3: funct3. Legal values are 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `req_a_i`, `req_b_i` in 32 (`word_t`): operands.
- `req_rd_i` in 5: destination register tag.
- `mul_start_o` out 1: start pulse to the multiplier.
- `mul_op_type_o` out 3: op code to the multiplier.
- `mul_a_o`, `mul_b_o` out 32: operands to the multiplier, combinational pass-through of `req_*`.
- `mul_result_i` in 32: multiplier result; valid only while `mul_done_i` is high.
- `mul_done_i` in 1: multiplier done.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: writeback accepts the response.
- `rsp_result_o` out 32: response result.
- `rsp_rd_o` out 5: response destination tag.
- `rsp_exc_o` out 1: response carries an exception.
- `rsp_cause_o` out 2 (`mdu_cause_e`): 00 none, 01 illegal op, 10 timeout.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- States are IDLE, WAIT and RESP. All registers and outputs reset to 0 and state resets to IDLE.
- `req_ready_o` = (IDLE | (RESP & `rsp_ready_i`)) & ~`flush_i`.
- Accept is `req_valid_i` & `req_ready_o`.
- Accept with a legal op:
  - `mul_start_o` = 1 in the same cycle (combinational).
  - Latch `req_rd_i`, clear the watchdog counter, and go to WAIT.
- Accept with an illegal op (1xx):
  - No start pulse.
  - Go to RESP with result 0, `rsp_exc_o`=1, cause 01, and the latched rd.
- WAIT:
  - The counter increments each cycle.
  - On `mul_done_i`: capture `mul_result_i` to `rsp_result_o`, set exc=0, and go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES` without done: go to RESP with result 0, exc=1, cause 10.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - `rsp_valid_o`=1, and the response registers are held stable while `rsp_ready_i`=0.
  - On handshake with no new accept: go to IDLE.
  - On handshake plus a new accept in the same cycle: load the new op (WAIT, or RESP if illegal).
- `mul_done_i` outside WAIT is ignored. This covers stale completions after a flush.
- `flush_i` has priority over everything:
  - Next state is IDLE and `rsp_valid_o` drops the next cycle.
  - No start is issued in the flush cycle.
- The multiplier cannot be aborted. A later start restarts its pipeline and discards the stale op.
- `rst_i` mid-operation behaves like flush plus clearing all registers.

## Timing
- Accept in cycle T:
  - `mul_start_o` high in T.
  - `mul_done_i` expected in T+`LATENCY`.
  - `rsp_valid_o` high from T+`LATENCY`+1.
- Total latency from request to response is `LATENCY`+1 cycles.
- Illegal op accepted in T gives `rsp_valid_o` in T+1.
- Throughput is one op per `LATENCY`+1 cycles, with RESP→WAIT back-to-back when `rsp_ready_i`=1.
- Timeout response appears at T+`TIMEOUT_CYCLES`+1.
- The counter width is $clog2(`TIMEOUT_CYCLES`+1) bits and saturates, with no wrap.

## Structure
- Shared package `riscv_core_pkg` holds:
  - The `mdu_cause_e` enum (2-bit).
  - The `MUL_OP_*` funct3 constants, reused by the multiplier.
  - `word_t`.
- `DEFAULT_MULT_LATENCY` lives in `riscv_config_pkg`.
- The FSM state enum is local to the module.
- Single flat module with no sub-modules. The bench instantiates it together with `mult_unit`.

## Test plan
- MUL: a=7, b=−3 (0xFFFFFFFD), rd=5, `LATENCY`=2.
  - Start in T, `rsp_valid_o` in T+3, result 0xFFFFFFEB, rd=5, exc=0.
- MULHU: a=b=0xFFFFFFFF, `rsp_ready_i` held 0 for 4 cycles.
  - Result 0xFFFFFFFE held stable.
  - `req_ready_o`=0 until the handshake.
- Back-to-back: a MULH (0x80000000 × 0x80000000, giving 0x40000000) is in RESP with `rsp_ready_i`=1 while a MULHSU (−1 × 2, giving 0xFFFFFFFF) is offered.
  - The second start occurs in the same cycle as the first response handshake.
  - Both results are correct and in order.
- `req_op_i`=3'b101.
  - No `mul_start_o`.
  - Next cycle: `rsp_valid_o`=1, exc=1, cause=01, result 0.
- `flush_i` one cycle after start.
  - IDLE the next cycle and no response.
  - The stale `mul_done_i` is ignored.
  - A new MUL 3×4 issued immediately returns 12.
- `mul_done_i` forced low.
  - Response at T+`TIMEOUT_CYCLES`+1 with exc=1, cause=10.
  - Separately, `rst_i` asserted in WAIT clears all outputs the next cycle.
